// File: rtl/bombe_crib_search.sv
// -----------------------------------------------------------------------------
// bombe_crib_search
// Bombe crib-search controller and datapath. A crib of CRIB_LEN ciphertext
// letters is captured one key press at a time. On 'go' every start position
// of a NUM_ROTORS-rotor Enigma core is swept: for each start position the
// external core is asked to encrypt 'A','B','C',... and each returned letter
// is compared with the stored crib. The first start position that reproduces
// the whole crib is reported, otherwise exhaustion is reported.
//
// Optional feature macro: BOMBE_CONTINUE_EN
//   defined   -> 'go' while FOUND resumes the search after the current hit
//   undefined -> FOUND is terminal until clear or reset
//
// Ports
//   clk         in   1       rising-edge clock
//   resetn      in   1       asynchronous active-low reset
//   key_press   in   1       high while a key is held
//   char_in     in   CHAR_W  ASCII letter, valid while key_press is high
//   go          in   1       starts the search from ARMED
//   clear       in   1       synchronous return to LOAD, wipes the crib
//   enc_req     out  1       encryption request to the core
//   enc_pos     out  POS_W   rotor position for the request
//   enc_char    out  CHAR_W  plaintext for the request ('A' + letter index)
//   enc_ack     in   1       core result valid
//   enc_result  in   CHAR_W  ciphertext returned by the core
//   load_idx    out  4       number of crib letters stored so far
//   busy        out  1       high in ISSUE or WAIT_ACK
//   found       out  1       high in FOUND
//   not_found   out  1       high in NOT_FOUND
//   result_pos  out  POS_W   matching start position, valid while found
// -----------------------------------------------------------------------------
module bombe_crib_search #(
    parameter int CRIB_LEN   = 3,
    parameter int NUM_ROTORS = 3,
    parameter int CHAR_W     = 8,
    parameter int DIG_W      = 5,
    parameter int POS_W      = NUM_ROTORS * DIG_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              key_press,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              go,
    input  logic              clear,
    output logic              enc_req,
    output logic [POS_W-1:0]  enc_pos,
    output logic [CHAR_W-1:0] enc_char,
    input  logic              enc_ack,
    input  logic [CHAR_W-1:0] enc_result,
    output logic [3:0]        load_idx,
    output logic              busy,
    output logic              found,
    output logic              not_found,
    output logic [POS_W-1:0]  result_pos
);

    localparam logic [2:0] S_LOAD      = 3'd0;
    localparam logic [2:0] S_LOAD_WAIT = 3'd1;
    localparam logic [2:0] S_ARMED     = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK  = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_FOUND     = 3'd6;
    localparam logic [2:0] S_NOT_FOUND = 3'd7;

    // load_cnt must be able to hold CRIB_LEN itself; idx only 0..CRIB_LEN-1
    localparam int IDX_W = (CRIB_LEN > 1) ? $clog2(CRIB_LEN) : 1;
    localparam int CNT_W = $clog2(CRIB_LEN + 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  load_cnt;
    logic [IDX_W-1:0]  idx;
    logic [POS_W-1:0]  cand;
    logic [POS_W-1:0]  work;
    logic [CHAR_W-1:0] crib [CRIB_LEN];

    logic [POS_W-1:0]  cand_inc;
    logic [POS_W-1:0]  work_inc;
    logic              is_letter;
    logic              letter_match;

    // Mixed-radix odometer increment: every 5-bit digit counts 0..25 and
    // carries into the next one; the top digit simply wraps to 0.
    function automatic logic [POS_W-1:0] odo_inc(input logic [POS_W-1:0] p);
        logic [POS_W-1:0] r;
        logic             carry;
        r     = p;
        carry = 1'b1;
        for (int d = 0; d < NUM_ROTORS; d++) begin
            if (carry) begin
                if (p[d*DIG_W +: DIG_W] == DIG_W'(25)) begin
                    r[d*DIG_W +: DIG_W] = '0;
                end else begin
                    r[d*DIG_W +: DIG_W] = p[d*DIG_W +: DIG_W] + DIG_W'(1);
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign cand_inc     = odo_inc(cand);
    assign work_inc     = odo_inc(work);
    assign is_letter    = (char_in >= CHAR_W'(65)) && (char_in <= CHAR_W'(90));
    assign letter_match = (enc_result == crib[idx]);

    // Request outputs are gated so everything idles at 0 outside a request
    assign busy      = (state == S_ISSUE) || (state == S_WAIT_ACK);
    assign enc_req   = busy;
    assign enc_pos   = busy ? work : '0;
    assign enc_char  = busy ? (CHAR_W'(65) + CHAR_W'(idx)) : '0;
    assign found     = (state == S_FOUND);
    assign not_found = (state == S_NOT_FOUND);
    // With CRIB_LEN=16 a full crib reads back as 0 on this 4-bit port
    assign load_idx  = 4'(load_cnt);

    // Main controller. clear has priority over every state action, so a key
    // arriving with clear is dropped and a pending ack is never looked at.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            idx        <= '0;
            cand       <= '0;
            work       <= '0;
            result_pos <= '0;
            for (int k = 0; k < CRIB_LEN; k++) crib[k] <= '0;
        end else if (clear) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            idx        <= '0;
            cand       <= '0;
            work       <= '0;
            result_pos <= '0;
            for (int k = 0; k < CRIB_LEN; k++) crib[k] <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (key_press && is_letter) begin
                        crib[load_cnt[IDX_W-1:0]] <= char_in;
                        load_cnt <= load_cnt + CNT_W'(1);
                        state    <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (!key_press) begin
                        state <= (load_cnt == CNT_W'(CRIB_LEN)) ? S_ARMED : S_LOAD;
                    end
                end
                S_ARMED: begin
                    if (go) begin
                        cand  <= '0;
                        work  <= '0;
                        idx   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // An ack here belongs to nothing and is deliberately ignored
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (enc_ack) begin
                        if (letter_match) begin
                            if (idx == IDX_W'(CRIB_LEN - 1)) begin
                                result_pos <= cand;
                                state      <= S_FOUND;
                            end else begin
                                idx   <= idx + IDX_W'(1);
                                work  <= work_inc;
                                state <= S_ISSUE;
                            end
                        end else begin
                            cand  <= cand_inc;
                            work  <= cand_inc;
                            idx   <= '0;
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    // cand back at 0 means the odometer rolled over every position
                    state <= (cand == '0) ? S_NOT_FOUND : S_ISSUE;
                end
                S_FOUND: begin
`ifdef BOMBE_CONTINUE_EN
                    if (go) begin
                        cand  <= cand_inc;
                        work  <= cand_inc;
                        idx   <= '0;
                        state <= S_NEXT;
                    end
`endif
                end
                S_NOT_FOUND: begin
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bombe_crib_search.sv
// -----------------------------------------------------------------------------
// tb_bombe_crib_search
// Directed bench for bombe_crib_search. Two instances share the keyboard,
// clear and reset lines: dut3 (3 rotors) and dut1 (1 rotor). Each has its own
// go line and its own behavioural Enigma core model that acks with a varying
// delay and only reproduces the crib at chosen start positions.
// Crib used throughout: "QXM".
// -----------------------------------------------------------------------------
module tb_bombe_crib_search;

    logic        clk;
    logic        resetn;
    logic        key_press;
    logic [7:0]  char_in;
    logic        go3, go1;
    logic        clear;

    logic        enc_req3, enc_req1;
    logic [14:0] enc_pos3;
    logic [4:0]  enc_pos1;
    logic [7:0]  enc_char3, enc_char1;
    logic [3:0]  load_idx3, load_idx1;
    logic        busy3, busy1, found3, found1, not_found3, not_found1;
    logic [14:0] result_pos3;
    logic [4:0]  result_pos1;

    logic        ack_m [2];
    logic [7:0]  res_m [2];
    logic        mreq  [2];
    logic [14:0] mpos  [2];
    logic [7:0]  mchar [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] crib_ref [3];
    int  hit_start [2][2];
    int  hit_len   [2][2];
    bit  pause [2];
    bit  junk  [2];
    int  inject_req  [2];
    int  inject_done [2];
    int  cnt  [2];
    int  acks [2];
    int  reqs [2];
    int  stab_err [2];
    logic [14:0] lat_pos  [2];
    logic [7:0]  lat_char [2];

    bombe_crib_search #(.CRIB_LEN(3), .NUM_ROTORS(3)) dut3 (
        .clk(clk), .resetn(resetn), .key_press(key_press), .char_in(char_in),
        .go(go3), .clear(clear), .enc_req(enc_req3), .enc_pos(enc_pos3),
        .enc_char(enc_char3), .enc_ack(ack_m[0]), .enc_result(res_m[0]),
        .load_idx(load_idx3), .busy(busy3), .found(found3),
        .not_found(not_found3), .result_pos(result_pos3)
    );

    bombe_crib_search #(.CRIB_LEN(3), .NUM_ROTORS(1)) dut1 (
        .clk(clk), .resetn(resetn), .key_press(key_press), .char_in(char_in),
        .go(go1), .clear(clear), .enc_req(enc_req1), .enc_pos(enc_pos1),
        .enc_char(enc_char1), .enc_ack(ack_m[1]), .enc_result(res_m[1]),
        .load_idx(load_idx1), .busy(busy1), .found(found1),
        .not_found(not_found1), .result_pos(result_pos1)
    );

    assign mreq[0]  = enc_req3;
    assign mreq[1]  = enc_req1;
    assign mpos[0]  = enc_pos3;
    assign mpos[1]  = {10'd0, enc_pos1};
    assign mchar[0] = enc_char3;
    assign mchar[1] = enc_char1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed position -> integer, digit 0 least significant, radix 26
    function automatic int pos2int(input logic [14:0] p, input int nr);
        int v;
        int m;
        v = 0;
        m = 1;
        for (int d = 0; d < nr; d++) begin
            v = v + int'(p[d*5 +: 5]) * m;
            m = m * 26;
        end
        return v;
    endfunction

    // Core answer: the crib letter only when this request lines up with a hit
    function automatic logic [7:0] model_result(input int k, input logic [14:0] p,
                                                input logic [7:0] ch);
        int i;
        int v;
        int tot;
        logic [7:0] r;
        i   = int'(ch) - 65;
        tot = (k == 0) ? 17576 : 26;
        v   = pos2int(p, (k == 0) ? 3 : 1);
        r   = 8'h2A;
        for (int h = 0; h < 2; h++) begin
            if (i >= 0 && i < 3 && i < hit_len[k][h] && v == (hit_start[k][h] + i) % tot)
                r = crib_ref[i];
        end
        return r;
    endfunction

    // Core models: one request at a time, ack after 0..3 extra cycles,
    // optional junk ack on the ISSUE cycle, request stability watched.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            ack_m[k] = 1'b0;
            if (inject_req[k] != inject_done[k]) begin
                ack_m[k] = 1'b1;
                res_m[k] = crib_ref[0];
                inject_done[k] = inject_req[k];
            end else if (mreq[k]) begin
                cnt[k] = cnt[k] + 1;
                if (cnt[k] == 1) begin
                    lat_pos[k]  = mpos[k];
                    lat_char[k] = mchar[k];
                    reqs[k]     = reqs[k] + 1;
                    if (junk[k] && mchar[k] >= 8'h41 && mchar[k] <= 8'h43) begin
                        ack_m[k] = 1'b1;
                        res_m[k] = crib_ref[int'(mchar[k]) - 65];
                    end
                end else if (mpos[k] !== lat_pos[k] || mchar[k] !== lat_char[k]) begin
                    stab_err[k] = stab_err[k] + 1;
                end
                if (!pause[k] && cnt[k] >= 2 + (acks[k] % 4)) begin
                    ack_m[k] = 1'b1;
                    res_m[k] = model_result(k, mpos[k], mchar[k]);
                    acks[k]  = acks[k] + 1;
                    cnt[k]   = 0;
                end
            end else begin
                cnt[k] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic key, input logic [7:0] ch, input logic g3,
                                 input logic g1, input logic clr);
        key_press = key;
        char_in   = ch;
        go3       = g3;
        go1       = g1;
        clear     = clr;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic loadCrib();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, crib_ref[n], 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, crib_ref[n], 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Bounded wait for found/not_found on one instance
    task automatic waitDone(input int k, input int budget, input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            done = (k == 0) ? (found3 | not_found3) : (found1 | not_found1);
            if (!done) tick();
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    int acks_base;
    int reqs_base;

    initial begin
        crib_ref[0] = 8'h51;
        crib_ref[1] = 8'h58;
        crib_ref[2] = 8'h4D;
        for (int k = 0; k < 2; k++) begin
            pause[k] = 1'b0; junk[k] = 1'b0;
            inject_req[k] = 0; inject_done[k] = 0;
            cnt[k] = 0; acks[k] = 0; reqs[k] = 0; stab_err[k] = 0;
            lat_pos[k] = '0; lat_char[k] = '0;
            ack_m[k] = 1'b0; res_m[k] = 8'h00;
            for (int h = 0; h < 2; h++) begin
                hit_start[k][h] = 0;
                hit_len[k][h]   = 0;
            end
        end
        hit_start[0][0] = 25;   hit_len[0][0] = 2;
        hit_start[0][1] = 2055; hit_len[0][1] = 3;
`ifdef BOMBE_CONTINUE_EN
        hit_start[1][0] = 5;    hit_len[1][0] = 3;
        hit_start[1][1] = 19;   hit_len[1][1] = 3;
`endif
        junk[1]  = 1'b1;
        pause[0] = 1'b1;

        resetn = 1'b0; key_press = 1'b0; char_in = 8'h00;
        go3 = 1'b0; go1 = 1'b0; clear = 1'b0;
        tick(); tick();
        checkOutput("rst enc_req", 32'(enc_req3), 32'd0);
        checkOutput("rst enc_pos", 32'(enc_pos3), 32'd0);
        checkOutput("rst enc_char", 32'(enc_char3), 32'd0);
        checkOutput("rst load_idx", 32'(load_idx3), 32'd0);
        checkOutput("rst flags", {29'd0, busy3, found3, not_found3}, 32'd0);
        checkOutput("rst result_pos", 32'(result_pos3), 32'd0);
        resetn = 1'b1;
        tick();

        // Keyboard loading, ignored keys and clear priority
        applyStimulus(1'b1, 8'h37, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("digit ignored", 32'(load_idx3), 32'd0);
        applyStimulus(1'b1, 8'h4B, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("clear beats key", 32'(load_idx3), 32'd0);
        applyStimulus(1'b1, crib_ref[0], 1'b0, 1'b0, 1'b0);
        checkOutput("load Q", 32'(load_idx3), 32'd1);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        checkOutput("held not stored", 32'(load_idx3), 32'd1);
        checkOutput("go in load ignored", 32'(busy3), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, crib_ref[1], 1'b0, 1'b0, 1'b0);
        checkOutput("load X", 32'(load_idx3), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, crib_ref[2], 1'b0, 1'b0, 1'b0);
        checkOutput("load M", 32'(load_idx3), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("key in armed ignored", 32'(load_idx3), 32'd3);
        inject_req[0]++;
        tick(); tick();
        checkOutput("ack without req", {30'd0, busy3, found3}, 32'd0);

        // First request, then clear while waiting for the ack
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("issue req", {enc_req3, 8'h00, enc_char3, 1'b0, enc_pos3}, {1'b1, 8'h00, 8'h41, 1'b0, 15'h0000});
        tick();
        checkOutput("wait req stable", {enc_req3, 8'h00, enc_char3, 1'b0, enc_pos3}, {1'b1, 8'h00, 8'h41, 1'b0, 15'h0000});
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("clear drops req", {31'd0, enc_req3}, 32'd0);
        clear = 1'b0;
        inject_req[0]++;
        tick(); tick();
        checkOutput("late ack ignored", {26'd0, busy3, found3, load_idx3}, 32'd0);

        // Reset in the middle of WAIT_ACK
        loadCrib();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        resetn = 1'b0;
        tick();
        checkOutput("midrst req/busy", {30'd0, enc_req3, busy3}, 32'd0);
        checkOutput("midrst pos/char", {9'd0, enc_pos3, enc_char3}, 32'd0);
        checkOutput("midrst load_idx", 32'(load_idx3), 32'd0);
        resetn = 1'b1;
        tick();

        // Full 3-rotor search: decoy partial match at 25, real hit at 0x0C21
        loadCrib();
        pause[0]  = 1'b0;
        acks_base = acks[0];
        reqs_base = reqs[0];
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        go3 = 1'b0;
        waitDone(0, 15000, "search3 done");
        checkOutput("search3 found", {30'd0, found3, not_found3}, 32'd2);
        checkOutput("search3 result_pos", 32'(result_pos3), 32'h0C21);
        checkOutput("search3 req idle", {30'd0, enc_req3, busy3}, 32'd0);
        checkOutput("search3 acks", 32'(acks[0] - acks_base), 32'd2060);
        checkOutput("search3 reqs", 32'(reqs[0] - reqs_base), 32'd2060);
        checkOutput("search3 stability", 32'(stab_err[0]), 32'd0);
`ifndef BOMBE_CONTINUE_EN
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("go in found ignored", {busy3, found3, 15'd0, result_pos3}, {1'b0, 1'b1, 15'd0, 15'h0C21});
`endif

        // Single-rotor search on the second instance
        acks_base = acks[1];
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        go1 = 1'b0;
`ifdef BOMBE_CONTINUE_EN
        waitDone(1, 500, "cont hit1 done");
        checkOutput("cont hit1", {found1, not_found1, 25'd0, result_pos1}, {1'b1, 1'b0, 25'd0, 5'd5});
        checkOutput("cont hit1 acks", 32'(acks[1] - acks_base), 32'd8);
        acks_base = acks[1];
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        go1 = 1'b0;
        waitDone(1, 500, "cont hit2 done");
        checkOutput("cont hit2", {found1, not_found1, 25'd0, result_pos1}, {1'b1, 1'b0, 25'd0, 5'd19});
        checkOutput("cont hit2 acks", 32'(acks[1] - acks_base), 32'd16);
        acks_base = acks[1];
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        go1 = 1'b0;
        waitDone(1, 500, "cont wrap done");
        checkOutput("cont wrap", {found1, not_found1, 25'd0, result_pos1}, {1'b0, 1'b1, 25'd0, 5'd19});
        checkOutput("cont wrap acks", 32'(acks[1] - acks_base), 32'd6);
`else
        waitDone(1, 500, "search1 done");
        checkOutput("search1 not_found", {30'd0, found1, not_found1}, 32'd1);
        checkOutput("search1 candidates", 32'(acks[1] - acks_base), 32'd26);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("go in not_found ignored", {29'd0, busy1, found1, not_found1}, 32'd1);
`endif
        checkOutput("search1 stability", 32'(stab_err[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
